// File: rtl/key_in.sv
// Keypad input device: synchronises and debounces an active-low key bus and
// presents KBSR/KBDR registers. Define KEY_IN_OVERRUN_EN to enable the KBSR[13] overrun flag.
module key_in #(
  parameter int DB_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  KEY_BUS,
  input  logic [15:0] MDR,
  input  logic        LD_KBSR,
  input  logic        RD_KBDR,
  output logic [15:0] KBSR,
  output logic [15:0] KBDR,
  output logic        INT
);

  // state      | meaning
  // IDLE       | all keys released, waiting for any pressed line
  // DB_PRESS   | candidate pattern captured, counting stable samples
  // HELD       | key registered, waiting for full release
  // DB_RELEASE | all lines released, counting stable released samples
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    cand, cand_nxt;
  logic [7:0]    sync_1, sync;
  logic          reg_key;
  logic          ready, ie, ovr;
  logic [15:0]   kbdr_q;
  logic [7:0]    key_mask;
  logic [2:0]    key_idx;
  logic          key_multi;
  logic          unused_mdr;

  assign unused_mdr = ^{MDR[15], MDR[13:0]};

  function automatic logic [2:0] lowest_idx(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Reset to all-released so a held key cannot look like a press during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 8'hFF;
      sync   <= 8'hFF;
    end else begin
      sync_1 <= KEY_BUS;
      sync   <= sync_1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= 8'hFF;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cand  <= cand_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    reg_key   = 1'b0;
    case (state)
      IDLE: begin
        if (sync != 8'hFF) begin
          cand_nxt  = sync;
          cnt_nxt   = '0;
          state_nxt = DB_PRESS;
        end
      end
      DB_PRESS: begin
        if (sync != cand) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          reg_key   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = HELD;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HELD: begin
        if (sync == 8'hFF) begin
          cnt_nxt   = '0;
          state_nxt = DB_RELEASE;
        end
      end
      DB_RELEASE: begin
        if (sync != 8'hFF) begin
          cnt_nxt   = '0;
          state_nxt = HELD;
        end else if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign key_mask  = ~cand;
  assign key_idx   = lowest_idx(key_mask);
  assign key_multi = (key_mask & (key_mask - 8'd1)) != 8'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kbdr_q <= 16'h0000;
    end else if (reg_key) begin
      kbdr_q <= {key_mask, 4'b0000, key_multi, key_idx};
    end
  end

  // A registration on the same edge as a read leaves ready set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready <= 1'b0;
      ie    <= 1'b0;
    end else begin
      if (reg_key)      ready <= 1'b1;
      else if (RD_KBDR) ready <= 1'b0;
      if (LD_KBSR)      ie <= MDR[14];
    end
  end

`ifdef KEY_IN_OVERRUN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr <= 1'b0;
    end else if (reg_key && ready) begin
      ovr <= 1'b1;
    end else if (RD_KBDR) begin
      ovr <= 1'b0;
    end
  end
`else
  assign ovr = 1'b0;
`endif

  assign KBSR = {ready, ie, ovr, 13'b0};
  assign KBDR = kbdr_q;
  assign INT  = ready & ie;

endmodule

// File: tb/tb_key_in.sv
// Self-checking bench for key_in with DB_CYCLES=4: directed scenarios plus
// randomized press/gap segments checked against a segment-level model.
module tb_key_in;

  localparam int DB = 4;
`ifdef KEY_IN_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [7:0]  key_bus;
  logic [15:0] mdr;
  logic        ld_kbsr;
  logic        rd_kbdr;
  logic [15:0] kbsr;
  logic [15:0] kbdr;
  logic        irq;

  int checks;
  int errors;

  key_in #(.DB_CYCLES(DB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .KEY_BUS (key_bus),
    .MDR     (mdr),
    .LD_KBSR (ld_kbsr),
    .RD_KBDR (rd_kbdr),
    .KBSR    (kbsr),
    .KBDR    (kbdr),
    .INT     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) tick();
  endtask

  // Expected KBDR for a pressed pattern, derived from the register's field definitions.
  function automatic logic [15:0] exp_kbdr(input logic [7:0] pat);
    logic [7:0] mask;
    int         first;
    int         nset;
    mask  = ~pat;
    first = -1;
    nset  = 0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        nset++;
        if (first < 0) first = i;
      end
    end
    if (first < 0) first = 0;
    return {mask, 4'b0000, (nset > 1) ? 1'b1 : 1'b0, 3'(first)};
  endfunction

  task automatic do_read();
    rd_kbdr = 1'b1;
    tick();
    rd_kbdr = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] val);
    mdr     = val;
    ld_kbsr = 1'b1;
    tick();
    ld_kbsr = 1'b0;
  endtask

  task automatic press_and_release(input logic [7:0] pat);
    key_bus = pat;
    wait_ticks(DB + 4);
    key_bus = 8'hFF;
    wait_ticks(DB + 4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (kbsr !== 16'h0000 || kbdr !== 16'h0000 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_in: KBSR=%h KBDR=%h INT=%b expected 0000 0000 0", kbsr, kbdr, irq);
    end
    wait_ticks(2);
    rst_n = 1'b1;
    wait_ticks(3);
    checks++;
    if (kbsr !== 16'h0000 || kbdr !== 16'h0000 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: KBSR=%h KBDR=%h INT=%b expected 0000 0000 0", kbsr, kbdr, irq);
    end
  endtask

  task automatic test_press_timing();
    key_bus = 8'hFB;
    for (int k = 0; k <= DB + 1; k++) begin
      tick();
      checks++;
      if (kbsr !== 16'h0000) begin
        errors++;
        $display("FAIL press_early edge N+%0d: KBSR=%h expected 0000", k, kbsr);
      end
    end
    tick();
    checks++;
    if (kbsr !== 16'h8000 || kbdr !== 16'h0402) begin
      errors++;
      $display("FAIL press_accept: KBSR=%h KBDR=%h expected 8000 0402", kbsr, kbdr);
    end
    key_bus = 8'hFF;
    wait_ticks(DB + 4);
    do_read();
    checks++;
    if (kbsr !== 16'h0000 || kbdr !== 16'h0402) begin
      errors++;
      $display("FAIL press_read: KBSR=%h KBDR=%h expected 0000 0402", kbsr, kbdr);
    end
  endtask

  task automatic test_glitch();
    key_bus = 8'hFE;
    wait_ticks(3);
    key_bus = 8'hFF;
    for (int k = 0; k < DB + 4; k++) begin
      tick();
      checks++;
      if (kbsr !== 16'h0000 || kbdr !== 16'h0402) begin
        errors++;
        $display("FAIL glitch cyc %0d: KBSR=%h KBDR=%h expected 0000 0402", k, kbsr, kbdr);
      end
    end
  endtask

  task automatic test_int_enable();
    do_load(16'h4000);
    checks++;
    if (kbsr !== 16'h4000 || irq !== 1'b0) begin
      errors++;
      $display("FAIL ie_load: KBSR=%h INT=%b expected 4000 0", kbsr, irq);
    end
    press_and_release(8'hF5);
    checks++;
    if (kbsr !== 16'hC000 || kbdr !== 16'h0A09 || irq !== 1'b1) begin
      errors++;
      $display("FAIL ie_press: KBSR=%h KBDR=%h INT=%b expected C000 0A09 1", kbsr, kbdr, irq);
    end
    do_read();
    checks++;
    if (kbsr !== 16'h4000 || irq !== 1'b0) begin
      errors++;
      $display("FAIL ie_read: KBSR=%h INT=%b expected 4000 0", kbsr, irq);
    end
    do_load(16'hBFFF);
    checks++;
    if (kbsr !== 16'h0000) begin
      errors++;
      $display("FAIL ie_clear: KBSR=%h expected 0000", kbsr);
    end
  endtask

  task automatic test_overrun();
    logic [15:0] exp_sr;
    press_and_release(8'hFE);
    press_and_release(8'h7F);
    exp_sr = OVR_EN ? 16'hA000 : 16'h8000;
    checks++;
    if (kbsr !== exp_sr || kbdr !== 16'h8007) begin
      errors++;
      $display("FAIL overrun: KBSR=%h KBDR=%h expected %h 8007", kbsr, kbdr, exp_sr);
    end
    do_read();
    checks++;
    if (kbsr !== 16'h0000 || kbdr !== 16'h8007) begin
      errors++;
      $display("FAIL overrun_read: KBSR=%h KBDR=%h expected 0000 8007", kbsr, kbdr);
    end
  endtask

  task automatic test_read_on_register();
    key_bus = 8'hFD;
    wait_ticks(DB + 2);
    rd_kbdr = 1'b1;
    tick();
    rd_kbdr = 1'b0;
    checks++;
    if (kbsr !== 16'h8000 || kbdr !== 16'h0201) begin
      errors++;
      $display("FAIL read_on_reg: KBSR=%h KBDR=%h expected 8000 0201", kbsr, kbdr);
    end
    key_bus = 8'hFF;
    wait_ticks(DB + 4);
    do_read();
  endtask

  task automatic test_reset_mid();
    do_load(16'h4000);
    key_bus = 8'hEF;
    wait_ticks(DB + 4);
    rst_n = 1'b0;
    #1;
    checks++;
    if (kbsr !== 16'h0000 || kbdr !== 16'h0000 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: KBSR=%h KBDR=%h INT=%b expected 0000 0000 0", kbsr, kbdr, irq);
    end
    wait_ticks(2);
    rst_n = 1'b1;
    wait_ticks(2);
    key_bus = 8'hFF;
    for (int k = 0; k < DB + 4; k++) begin
      tick();
      checks++;
      if (kbsr !== 16'h0000) begin
        errors++;
        $display("FAIL reset_held cyc %0d: KBSR=%h expected 0000", k, kbsr);
      end
    end
    key_bus = 8'hDF;
    wait_ticks(4);
    rst_n = 1'b0;
    #1;
    checks++;
    if (kbsr !== 16'h0000 || kbdr !== 16'h0000) begin
      errors++;
      $display("FAIL reset_debounce: KBSR=%h KBDR=%h expected 0000 0000", kbsr, kbdr);
    end
    key_bus = 8'hFF;
    wait_ticks(2);
    rst_n = 1'b1;
    wait_ticks(DB + 4);
    checks++;
    if (kbsr !== 16'h0000 || kbdr !== 16'h0000) begin
      errors++;
      $display("FAIL reset_after: KBSR=%h KBDR=%h expected 0000 0000", kbsr, kbdr);
    end
    press_and_release(8'h7F);
    checks++;
    if (kbsr !== 16'h8000 || kbdr !== 16'h8007) begin
      errors++;
      $display("FAIL reset_fresh: KBSR=%h KBDR=%h expected 8000 8007", kbsr, kbdr);
    end
    do_read();
  endtask

  // Model works per segment: a press of L samples followed by G released
  // samples. A key registers only if the device was re-armed by a long enough
  // release and the pattern lasted DB+1 samples.
  task automatic test_random();
    logic        armed;
    logic        m_ready, m_ie, m_ovr;
    logic [15:0] m_kbdr;
    logic [7:0]  pat;
    logic [15:0] exp_sr;
    int          len, gap;
    logic        do_rd, do_ld;
    logic [15:0] ld_val;
    armed   = 1'b1;
    m_ready = 1'b0;
    m_ie    = 1'b0;
    m_ovr   = 1'b0;
    m_kbdr  = 16'h8007;
    for (int s = 0; s < 40; s++) begin
      pat    = 8'($urandom_range(0, 254));
      len    = $urandom_range(1, DB + 4);
      gap    = $urandom_range(3, DB + 4);
      do_rd  = 1'($urandom_range(0, 1));
      do_ld  = ($urandom_range(0, 3) == 0);
      ld_val = 16'($urandom);
      key_bus = pat;
      wait_ticks(len);
      key_bus = 8'hFF;
      wait_ticks(gap - 1);
      rd_kbdr = do_rd;
      ld_kbsr = do_ld;
      mdr     = ld_val;
      tick();
      rd_kbdr = 1'b0;
      ld_kbsr = 1'b0;
      if (armed && len >= DB + 1) begin
        if (OVR_EN && m_ready) m_ovr = 1'b1;
        m_ready = 1'b1;
        m_kbdr  = exp_kbdr(pat);
        armed   = (gap >= DB + 1);
      end else if (!armed) begin
        armed = (gap >= DB + 1);
      end
      if (do_rd) begin
        m_ready = 1'b0;
        m_ovr   = 1'b0;
      end
      if (do_ld) m_ie = ld_val[14];
      exp_sr = {m_ready, m_ie, m_ovr, 13'b0};
      checks++;
      if (kbsr !== exp_sr || kbdr !== m_kbdr || irq !== (m_ready & m_ie)) begin
        errors++;
        $display("FAIL random seg %0d pat=%h L=%0d G=%0d: KBSR=%h KBDR=%h INT=%b expected %h %h %b",
                 s, pat, len, gap, kbsr, kbdr, irq, exp_sr, m_kbdr, m_ready & m_ie);
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    key_bus = 8'hFF;
    mdr     = 16'h0000;
    ld_kbsr = 1'b0;
    rd_kbdr = 1'b0;
    test_reset();
    test_press_timing();
    test_glitch();
    test_int_enable();
    test_overrun();
    test_read_on_register();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
